// File: rtl/reset_sequencer.sv
// reset_sequencer: power-up and recovery sequencer for the SoC clock/reset tree.
// Runs on the raw 12 MHz board clock, upstream of the PLL. It holds the PLL in reset,
// waits for a stable lock, releases the system reset and then, after a settling
// delay, the camera reset. It retries PLL bring-up on lock timeout, restarts on lock
// loss and serves software-requested system resets without re-locking the PLL.
//
// All outputs are flops loaded from the decoded next state. They therefore change on
// the same edge as the state register and have no combinational path from an input.
module reset_sequencer #(
    parameter int PLL_RESET_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 12000,
    parameter int LOCK_STABLE_CYCLES  = 32,
    parameter int CAM_DELAY_CYCLES    = 24000,
    parameter int SOFT_RESET_CYCLES   = 16
) (
    input  logic       clock12MHz,
    input  logic       nReset,
    input  logic       pllLocked,
    input  logic       softResetRequest,
    output logic       pllReset,
    output logic       systemReset,
    output logic       camnReset,
    output logic       resetDone,
    output logic [3:0] lockRetries,
    output logic [7:0] lockLossCount,
    output logic [2:0] sequencerState
);

    // State encodings are visible to firmware through sequencerState.
    localparam logic [2:0] PLL_RESET   = 3'd0;
    localparam logic [2:0] WAIT_LOCK   = 3'd1;
    localparam logic [2:0] LOCK_STABLE = 3'd2;
    localparam logic [2:0] CAM_DELAY   = 3'd3;
    localparam logic [2:0] RUN         = 3'd4;
    localparam logic [2:0] SOFT_RESET  = 3'd5;

    // A state that waits N cycles leaves on the edge where counter == N-1.
    localparam logic [19:0] PLL_RESET_LAST    = 20'(PLL_RESET_CYCLES - 1);
    localparam logic [19:0] LOCK_TIMEOUT_LAST = 20'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [19:0] LOCK_STABLE_LAST  = 20'(LOCK_STABLE_CYCLES - 1);
    localparam logic [19:0] CAM_DELAY_LAST    = 20'(CAM_DELAY_CYCLES - 1);
    localparam logic [19:0] SOFT_RESET_LAST   = 20'(SOFT_RESET_CYCLES - 1);

    logic        lockMeta;
    logic        lockSync;
    logic        reqMeta;
    logic        reqSync;
    logic        reqPrev;
    logic        softEdge;

    logic [2:0]  state;
    logic [2:0]  nextState;
    logic [19:0] counter;
    logic        retryInc;
    logic        lossInc;

    logic        nextPllReset;
    logic        nextSystemReset;
    logic        nextCamnReset;
    logic        nextResetDone;

    // Two-flop synchronizers for the asynchronous lock and request inputs, plus the
    // delayed request copy used for rising-edge detection.
    always_ff @(posedge clock12MHz or negedge nReset) begin
        if (!nReset) begin
            lockMeta <= 1'b0;
            lockSync <= 1'b0;
            reqMeta  <= 1'b0;
            reqSync  <= 1'b0;
            reqPrev  <= 1'b0;
        end else begin
            lockMeta <= pllLocked;
            lockSync <= lockMeta;
            reqMeta  <= softResetRequest;
            reqSync  <= reqMeta;
            reqPrev  <= reqSync;
        end
    end

    // A held-high request yields exactly one pulse; a new rising edge is needed.
    assign softEdge = reqSync & ~reqPrev;

    // State register, dwell counter, saturating status counters and output flops.
    // The dwell counter may wrap while sitting in RUN; RUN has no timed exit.
    always_ff @(posedge clock12MHz or negedge nReset) begin
        if (!nReset) begin
            state         <= PLL_RESET;
            counter       <= '0;
            lockRetries   <= '0;
            lockLossCount <= '0;
            pllReset      <= 1'b1;
            systemReset   <= 1'b1;
            camnReset     <= 1'b0;
            resetDone     <= 1'b0;
        end else begin
            state   <= nextState;
            counter <= (nextState != state) ? '0 : counter + 20'd1;
            if (retryInc && (lockRetries != 4'hF)) begin
                lockRetries <= lockRetries + 4'd1;
            end
            if (lossInc && (lockLossCount != 8'hFF)) begin
                lockLossCount <= lockLossCount + 8'd1;
            end
            pllReset    <= nextPllReset;
            systemReset <= nextSystemReset;
            camnReset   <= nextCamnReset;
            resetDone   <= nextResetDone;
        end
    end

    // Next-state selection. Lock loss is tested first so it beats a soft reset edge,
    // and lock detection in WAIT_LOCK beats the timeout.
    always_comb begin
        nextState = state;
        retryInc  = 1'b0;
        lossInc   = 1'b0;
        case (state)
            PLL_RESET: begin
                if (counter == PLL_RESET_LAST) nextState = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lockSync) begin
                    nextState = LOCK_STABLE;
                end else if (counter == LOCK_TIMEOUT_LAST) begin
                    nextState = PLL_RESET;
                    retryInc  = 1'b1;
                end
            end
            LOCK_STABLE: begin
                // Lock was never stable here, so this counts as a retry, not a loss.
                if (!lockSync) begin
                    nextState = PLL_RESET;
                    retryInc  = 1'b1;
                end else if (counter == LOCK_STABLE_LAST) begin
                    nextState = CAM_DELAY;
                end
            end
            CAM_DELAY: begin
                if (!lockSync) begin
                    nextState = PLL_RESET;
                    lossInc   = 1'b1;
                end else if (counter == CAM_DELAY_LAST) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                if (!lockSync) begin
                    nextState = PLL_RESET;
                    lossInc   = 1'b1;
                end else if (softEdge) begin
                    nextState = SOFT_RESET;
                end
            end
            SOFT_RESET: begin
                if (!lockSync) begin
                    nextState = PLL_RESET;
                    lossInc   = 1'b1;
                end else if (counter == SOFT_RESET_LAST) begin
                    nextState = CAM_DELAY;
                end
            end
            default: begin
                // Encodings 6 and 7 are unreachable; recover through a full re-lock.
                nextState = PLL_RESET;
            end
        endcase
    end

    // Output decode of the next state, loaded into the output flops above.
    always_comb begin
        nextPllReset    = 1'b1;
        nextSystemReset = 1'b1;
        nextCamnReset   = 1'b0;
        nextResetDone   = 1'b0;
        case (nextState)
            WAIT_LOCK, LOCK_STABLE, SOFT_RESET: begin
                nextPllReset = 1'b0;
            end
            CAM_DELAY: begin
                nextPllReset    = 1'b0;
                nextSystemReset = 1'b0;
            end
            RUN: begin
                nextPllReset    = 1'b0;
                nextSystemReset = 1'b0;
                nextCamnReset   = 1'b1;
                nextResetDone   = 1'b1;
            end
            default: begin
                nextPllReset = 1'b1;
            end
        endcase
    end

    assign sequencerState = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: bench for reset_sequencer with shortened delays.
// Reference model: a phase/dwell-time description of the sequence driven by the input
// samples as seen two edges later. It predicts every change of the output vector with
// its edge number; a monitor compares each observed change against that queue.
`timescale 1ns/1ps
module tb_reset_sequencer;

    localparam int P = 16;   // PLL reset hold
    localparam int T = 200;  // lock timeout
    localparam int S = 32;   // lock stable time
    localparam int C = 300;  // camera delay
    localparam int R = 16;   // soft reset hold
    localparam int W = 51;   // {edge[31:0], state[2:0], outs[3:0], retries[3:0], losses[7:0]}
    localparam logic [18:0] RESET_VEC = {3'd0, 4'b1100, 4'd0, 8'd0};

    logic       clock12MHz = 1'b0;
    logic       nReset = 1'b1;
    logic       pllLocked = 1'b0;
    logic       softResetRequest = 1'b0;
    logic       pllReset;
    logic       systemReset;
    logic       camnReset;
    logic       resetDone;
    logic [3:0] lockRetries;
    logic [7:0] lockLossCount;
    logic [2:0] sequencerState;

    reset_sequencer #(
        .PLL_RESET_CYCLES(P),
        .LOCK_TIMEOUT_CYCLES(T),
        .LOCK_STABLE_CYCLES(S),
        .CAM_DELAY_CYCLES(C),
        .SOFT_RESET_CYCLES(R)
    ) dut (
        .clock12MHz(clock12MHz),
        .nReset(nReset),
        .pllLocked(pllLocked),
        .softResetRequest(softResetRequest),
        .pllReset(pllReset),
        .systemReset(systemReset),
        .camnReset(camnReset),
        .resetDone(resetDone),
        .lockRetries(lockRetries),
        .lockLossCount(lockLossCount),
        .sequencerState(sequencerState)
    );

    // ---------------- clock ----------------
    always #5 clock12MHz = ~clock12MHz;

    int checks = 0;
    int errors = 0;
    int cyc = 0;  // number of rising edges so far

    logic [W-1:0] expQ[$];

    // ---------------- reference model ----------------
    int          mState = 0;
    int          mEntry = 0;
    int          mRetries = 0;
    int          mLoss = 0;
    logic        lockHist[$];
    logic        reqHist[$];
    logic [18:0] lastPushed = RESET_VEC;

    // {pllReset, systemReset, camnReset, resetDone} for each phase
    function automatic logic [3:0] outsFor(input int st);
        case (st)
            1, 2, 5: return 4'b0100;
            3:       return 4'b0000;
            4:       return 4'b0011;
            default: return 4'b1100;
        endcase
    endfunction

    function automatic logic [18:0] modelVec();
        return {3'(mState), outsFor(mState), 4'(mRetries), 8'(mLoss)};
    endfunction

    task automatic pushExp(input int stamp);
        logic [18:0] v;
        v = modelVec();
        if (v != lastPushed) begin
            expQ.push_back({32'(stamp), v});
            lastPushed = v;
        end
    endtask

    // Reset is asserted between edges; the change is first sampled after the next edge.
    task automatic modelReset();
        mState = 0;
        mRetries = 0;
        mLoss = 0;
        mEntry = cyc;
        lockHist.delete();
        reqHist.delete();
        repeat (2) lockHist.push_back(1'b0);
        repeat (3) reqHist.push_back(1'b0);
        pushExp(cyc + 1);
    endtask

    task automatic modelStep();
        int   dw;
        int   nxt;
        logic ls;
        logic se;
        logic ri;
        logic li;
        dw  = cyc - mEntry;          // edges since the phase was entered
        ls  = lockHist[0];           // lock as sampled two edges ago
        se  = reqHist[1] & ~reqHist[0];
        nxt = mState;
        ri  = 1'b0;
        li  = 1'b0;
        if (mState >= 3 && mState <= 5 && !ls) begin
            nxt = 0;
            li  = 1'b1;
        end else begin
            case (mState)
                0: if (dw == P) nxt = 1;
                1: begin
                    if (ls) nxt = 2;
                    else if (dw == T) begin nxt = 0; ri = 1'b1; end
                end
                2: begin
                    if (!ls) begin nxt = 0; ri = 1'b1; end
                    else if (dw == S) nxt = 3;
                end
                3: if (dw == C) nxt = 4;
                4: if (se) nxt = 5;
                5: if (dw == R) nxt = 3;
                default: nxt = 0;
            endcase
        end
        if (nxt != mState) begin
            mState = nxt;
            mEntry = cyc;
        end
        if (ri && mRetries < 15) mRetries++;
        if (li && mLoss < 255) mLoss++;
        void'(lockHist.pop_front());
        lockHist.push_back(pllLocked);
        void'(reqHist.pop_front());
        reqHist.push_back(softResetRequest);
        pushExp(cyc);
    endtask

    initial begin
        wait (nReset == 1'b0);
        forever begin
            @(posedge clock12MHz);
            cyc++;
            if (!nReset) mEntry = cyc;
            else modelStep();
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [18:0]  last;
        logic [18:0]  act;
        logic [W-1:0] got;
        logic [W-1:0] want;
        last = RESET_VEC;
        @(negedge nReset);
        forever begin
            @(negedge clock12MHz);
            act = {sequencerState, pllReset, systemReset, camnReset, resetDone,
                   lockRetries, lockLossCount};
            if (act !== last) begin
                got = {32'(cyc), act};
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard: unexpected change to %h at edge %0d, required no change",
                             act, cyc);
                end else begin
                    want = expQ.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL scoreboard: got edge %0d vec %h, required edge %0d vec %h",
                                 got[50:19], got[18:0], want[50:19], want[18:0]);
                    end
                end
                last = act;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic applyReset(input int holdCycles);
        @(negedge clock12MHz);
        #1;
        nReset = 1'b0;
        modelReset();
        #1;
        checkEq("resetValues",
                32'({sequencerState, pllReset, systemReset, camnReset, resetDone,
                     lockRetries, lockLossCount}), 32'(RESET_VEC));
        repeat (holdCycles) @(posedge clock12MHz);
        @(negedge clock12MHz);
        nReset = 1'b1;
    endtask

    task automatic waitEdge(input int target);
        while (cyc < target) @(negedge clock12MHz);
    endtask

    task automatic waitState(input logic [2:0] st, input int budget, input string name);
        int n;
        n = 0;
        while (sequencerState !== st && n < budget) begin
            @(negedge clock12MHz);
            n++;
        end
        checks++;
        if (sequencerState !== st) begin
            errors++;
            $display("FAIL %s: state %0d after %0d cycles, required %0d", name, sequencerState, n, st);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int rel;
        int t0;
        int act;
        int n;

        // Cold boot with lock present throughout.
        pllLocked = 1'b1;
        applyReset(3);
        rel = cyc;
        waitEdge(rel + P - 1);
        checkEq("coldPllHeld", 32'(pllReset), 32'd1);
        waitEdge(rel + P);
        checkEq("coldPllRelease", 32'(pllReset), 32'd0);
        waitEdge(rel + P + 1 + S - 1);
        checkEq("coldSysHeld", 32'(systemReset), 32'd1);
        waitEdge(rel + P + 1 + S);
        checkEq("coldSysRelease", 32'(systemReset), 32'd0);
        waitEdge(rel + P + 1 + S + C - 1);
        checkEq("coldCamHeld", 32'({camnReset, resetDone}), 32'd0);
        waitEdge(rel + P + 1 + S + C);
        checkEq("coldCamRelease", 32'({camnReset, resetDone}), 32'd3);
        checkEq("coldCounters", 32'({lockRetries, lockLossCount}), 32'd0);

        // Lock absent across two timeouts.
        pllLocked = 1'b0;
        applyReset(2);
        rel = cyc;
        waitEdge(rel + P + T - 1);
        checkEq("timeoutWaitLow", 32'(pllReset), 32'd0);
        waitEdge(rel + P + T);
        checkEq("timeoutPulseHigh", 32'(pllReset), 32'd1);
        waitEdge(rel + 2 * P + T - 1);
        checkEq("timeoutPulseHold", 32'(pllReset), 32'd1);
        waitEdge(rel + 2 * P + T);
        checkEq("timeoutPulseEnd", 32'(pllReset), 32'd0);
        waitEdge(rel + 2 * (P + T) + 60);
        pllLocked = 1'b1;
        waitState(3'd4, 4000, "timeoutRecoverRun");
        checkEq("timeoutRetries", 32'(lockRetries), 32'd2);

        // Lock dropped at cycle 20 of LOCK_STABLE.
        applyReset(2);
        waitState(3'd2, 200, "stableEnter");
        t0 = cyc;
        waitEdge(t0 + 18);
        pllLocked = 1'b0;
        waitState(3'd0, 10, "stableDropPll");
        checkEq("stableDropSys", 32'(systemReset), 32'd1);
        checkEq("stableDropCounts", 32'({lockRetries, lockLossCount}), 32'h100);
        pllLocked = 1'b1;
        waitState(3'd4, 4000, "stableRecoverRun");

        // Lock loss in RUN: outputs fall back three edges after the input change.
        t0 = cyc;
        pllLocked = 1'b0;
        waitEdge(t0 + 2);
        checkEq("runLossNotYet", 32'(pllReset), 32'd0);
        waitEdge(t0 + 3);
        checkEq("runLossOuts", 32'({pllReset, systemReset, camnReset}), 32'b110);
        checkEq("runLossCount", 32'(lockLossCount), 32'd1);
        pllLocked = 1'b1;
        waitState(3'd4, 4000, "runLossResequence");

        // Software reset with the request held high.
        t0 = cyc;
        softResetRequest = 1'b1;
        waitEdge(t0 + 3);
        checkEq("softEnter", 32'({sequencerState, pllReset, systemReset}), 32'({3'd5, 2'b01}));
        waitEdge(t0 + 3 + R - 1);
        checkEq("softHold", 32'(systemReset), 32'd1);
        waitEdge(t0 + 3 + R);
        checkEq("softToCam", 32'({sequencerState, pllReset, systemReset}), 32'({3'd3, 2'b00}));
        waitEdge(t0 + 3 + R + C);
        checkEq("softToRun", 32'(sequencerState), 32'd4);
        repeat (50) @(negedge clock12MHz);
        checkEq("softNoRepeat", 32'(sequencerState), 32'd4);
        softResetRequest = 1'b0;
        repeat (5) @(negedge clock12MHz);

        // Simultaneous soft edge and lock loss.
        t0 = cyc;
        softResetRequest = 1'b1;
        pllLocked = 1'b0;
        waitEdge(t0 + 3);
        checkEq("simulState", 32'(sequencerState), 32'd0);
        checkEq("simulLoss", 32'(lockLossCount), 32'd2);
        pllLocked = 1'b1;
        softResetRequest = 1'b0;
        waitState(3'd3, 4000, "simulReachCam");

        // Reset pulsed in CAM_DELAY (values checked inside applyReset).
        repeat (10) @(negedge clock12MHz);
        applyReset(2);

        // Retry counter saturation.
        pllLocked = 1'b0;
        applyReset(2);
        repeat (16 * (P + T) + 20) @(negedge clock12MHz);
        checkEq("retrySaturate", 32'(lockRetries), 32'd15);
        pllLocked = 1'b1;
        waitState(3'd4, 4000, "saturateRecoverRun");

        // Randomized mix of lock glitches, request pulses, idle time and resets.
        for (int it = 0; it < 40; it++) begin
            act = int'($urandom_range(0, 9));
            if (act < 3) begin
                pllLocked = 1'b0;
                n = int'($urandom_range(1, T + 40));
                repeat (n) @(negedge clock12MHz);
                pllLocked = 1'b1;
            end else if (act < 6) begin
                softResetRequest = 1'b1;
                n = int'($urandom_range(1, 30));
                repeat (n) @(negedge clock12MHz);
                softResetRequest = 1'b0;
                n = int'($urandom_range(1, 30));
                repeat (n) @(negedge clock12MHz);
            end else if (act < 9) begin
                n = int'($urandom_range(20, C + S + P + 60));
                repeat (n) @(negedge clock12MHz);
            end else begin
                applyReset(int'($urandom_range(2, 5)));
            end
        end

        // ---------------- final report ----------------
        repeat (10) @(negedge clock12MHz);
        checkEq("scoreboardDrain", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
